// File: rtl/uart_pkg.sv
// Shared types and constants for the APB-programmed UART transmitter:
// FSM states, register addresses, LCR field layout and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [7:0] ADDR_THR = 8'h00;
  localparam logic [7:0] ADDR_LCR = 8'h04;
  localparam logic [7:0] ADDR_DLL = 8'h08;
  localparam logic [7:0] ADDR_DLM = 8'h0C;
  localparam logic [7:0] ADDR_LSR = 8'h10;
  localparam logic [7:0] ADDR_CNT = 8'h14;

  localparam logic [7:0] LCR_RESET = 8'h03;

  typedef struct packed {
    logic       irq_en;
    logic       brk;
    logic       stick;
    logic       even;
    logic       par_en;
    logic       stop2;
    logic [1:0] wlen;
  } lcr_t;

  // Parity over the active word length; stick mode ignores the data entirely.
  function automatic logic calc_parity(input logic [7:0] data, input lcr_t lcr);
    logic [7:0] m;
    case (lcr.wlen)
      2'd0:    m = 8'h1F;
      2'd1:    m = 8'h3F;
      2'd2:    m = 8'h7F;
      default: m = 8'hFF;
    endcase
    if (lcr.stick) begin
      calc_parity = ~lcr.even;
    end else if (lcr.even) begin
      calc_parity = ^(data & m);
    end else begin
      calc_parity = ~(^(data & m));
    end
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; a push while full is
// accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == CW'(0));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage array; reset only clears pointers so stale words are unreachable.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_apb_tx.sv
// APB-programmed UART transmitter: register file, TX FIFO, baud counter and
// framing FSM. Frame settings are captured when a frame starts.
module uart_apb_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  output logic       UART_SOUT,
  output logic       TXDRDYn,
  output logic       tx_irq
);
  import uart_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(FIFO_DEPTH / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  lcr_t             r_lcr, r_lcr_lat, w_lcr_lat_nxt;
  logic [7:0]       r_dll, r_dlm, r_data, w_data_nxt, r_shift, w_shift_nxt, w_prdata, w_lsr;
  logic             r_ovf, r_sout, w_sout_nxt, r_txdrdyn;
  logic [DIV_W-1:0] r_baud, w_baud_nxt, r_div_lat, w_div_lat_nxt, w_div;
  logic [15:0]      w_div16;
  logic [2:0]       r_bit, w_bit_nxt;
  uart_state_e      r_state, w_state_nxt;
  logic             w_acc, w_wr, w_mapped, w_err, w_thr_full_wr, w_push, w_pop, w_start;
  logic             w_can_start, w_tick, w_idle;
  logic             w_fifo_full, w_fifo_empty;
  logic [7:0]       w_fifo_rdata;
  logic [CNT_W-1:0] w_fifo_cnt;

  assign w_acc    = PSEL & PENABLE;
  assign w_wr     = w_acc & PWRITE;
  assign w_mapped = (PADDR == ADDR_THR) | (PADDR == ADDR_LCR) | (PADDR == ADDR_DLL) |
                    (PADDR == ADDR_DLM) | (PADDR == ADDR_LSR) | (PADDR == ADDR_CNT);
  // A full-FIFO write still succeeds if the transmitter pops in the same cycle.
  assign w_thr_full_wr = w_wr & (PADDR == ADDR_THR) & w_fifo_full & ~w_pop;
  assign w_err    = w_acc & (~w_mapped | ((PADDR == ADDR_THR) & ~PWRITE) | w_thr_full_wr);
  assign w_push   = w_wr & (PADDR == ADDR_THR) & ~w_thr_full_wr;

  assign w_div16     = {r_dlm, r_dll};
  assign w_div       = w_div16[DIV_W-1:0];
  assign w_can_start = ~w_fifo_empty & (w_div != {DIV_W{1'b0}});
  assign w_tick      = (r_baud == (r_div_lat - DIV_ONE));
  assign w_idle      = w_fifo_empty & (r_state == ST_IDLE);
  assign w_lsr       = {4'b0000, r_ovf, w_idle, w_fifo_full, w_fifo_empty};

  assign PREADY    = 1'b1;
  assign PSLVERR   = w_err;
  assign PRDATA    = w_prdata;
  assign UART_SOUT = r_sout;
  assign TXDRDYn   = r_txdrdyn;
  assign tx_irq    = r_lcr.irq_en & (w_lsr[2] | w_lsr[3]);

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (PCLK),
    .i_rst_n (PRESETn),
    .i_push  (w_push),
    .i_wdata (PWDATA),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

  // Read mux, driven only while selected.
  always_comb begin
    w_prdata = 8'h00;
    if (PSEL) begin
      case (PADDR)
        ADDR_LCR: w_prdata = r_lcr;
        ADDR_DLL: w_prdata = r_dll;
        ADDR_DLM: w_prdata = (DIV_W == 16) ? r_dlm : 8'h00;
        ADDR_LSR: w_prdata = w_lsr;
        ADDR_CNT: w_prdata = 8'(w_fifo_cnt);
        default:  w_prdata = 8'h00;
      endcase
    end else begin
      w_prdata = 8'h00;
    end
  end

  // Control registers, sticky overflow and DMA request.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_lcr     <= lcr_t'(LCR_RESET);
      r_dll     <= 8'h00;
      r_dlm     <= 8'h00;
      r_ovf     <= 1'b0;
      r_txdrdyn <= 1'b0;
    end else begin
      if (w_wr && PADDR == ADDR_LCR) r_lcr <= lcr_t'(PWDATA);
      if (w_wr && PADDR == ADDR_DLL) r_dll <= PWDATA;
      if (w_wr && PADDR == ADDR_DLM && DIV_W == 16) r_dlm <= PWDATA;
      if (w_thr_full_wr) begin
        r_ovf <= 1'b1;
      end else if (w_wr && PADDR == ADDR_LSR && PWDATA[3]) begin
        r_ovf <= 1'b0;
      end
      r_txdrdyn <= (w_fifo_cnt >= HALF_CNT);
    end
  end

  // Framing FSM state and datapath registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= ST_IDLE;
      r_baud    <= {DIV_W{1'b0}};
      r_div_lat <= {DIV_W{1'b0}};
      r_lcr_lat <= lcr_t'(LCR_RESET);
      r_data    <= 8'h00;
      r_shift   <= 8'h00;
      r_bit     <= 3'd0;
      r_sout    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_div_lat <= w_div_lat_nxt;
      r_lcr_lat <= w_lcr_lat_nxt;
      r_data    <= w_data_nxt;
      r_shift   <= w_shift_nxt;
      r_bit     <= w_bit_nxt;
      r_sout    <= w_sout_nxt;
    end
  end

  // Next-state logic; the serial bit is derived from the next state so the
  // line changes on the same edge the FSM does.
  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud;
    w_div_lat_nxt = r_div_lat;
    w_lcr_lat_nxt = r_lcr_lat;
    w_data_nxt    = r_data;
    w_shift_nxt   = r_shift;
    w_bit_nxt     = r_bit;
    w_start       = 1'b0;
    w_pop         = 1'b0;
    w_sout_nxt    = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_can_start) w_start = 1'b1;
        else             w_state_nxt = ST_IDLE;
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = 3'd0;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (w_tick && r_bit == {1'b1, r_lcr_lat.wlen}) begin
          w_state_nxt = r_lcr_lat.par_en ? ST_PARITY : ST_STOP;
          w_bit_nxt   = 3'd0;
        end else if (w_tick) begin
          w_bit_nxt   = r_bit + 3'd1;
          w_shift_nxt = {1'b0, r_shift[7:1]};
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (w_tick) w_state_nxt = ST_STOP;
        else        w_state_nxt = ST_PARITY;
      end
      ST_STOP: begin
        if (w_tick && r_lcr_lat.stop2 && r_bit == 3'd0) begin
          w_bit_nxt = 3'd1;
        end else if (w_tick && w_can_start) begin
          w_start = 1'b1;
        end else if (w_tick) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_start) begin
      w_state_nxt   = ST_START;
      w_pop         = 1'b1;
      w_baud_nxt    = {DIV_W{1'b0}};
      w_div_lat_nxt = w_div;
      w_lcr_lat_nxt = r_lcr;
      w_data_nxt    = w_fifo_rdata;
      w_shift_nxt   = w_fifo_rdata;
      w_bit_nxt     = 3'd0;
    end else if (r_state == ST_IDLE || w_tick) begin
      w_baud_nxt = {DIV_W{1'b0}};
    end else begin
      w_baud_nxt = r_baud + DIV_ONE;
    end

    case (w_state_nxt)
      ST_IDLE:   w_sout_nxt = 1'b1;
      ST_START:  w_sout_nxt = 1'b0;
      ST_DATA:   w_sout_nxt = w_shift_nxt[0];
      ST_PARITY: w_sout_nxt = calc_parity(r_data, r_lcr_lat);
      ST_STOP:   w_sout_nxt = 1'b1;
      default:   w_sout_nxt = 1'b1;
    endcase
    if (r_lcr.brk) w_sout_nxt = 1'b0;
    else           w_sout_nxt = w_sout_nxt;
  end

endmodule

// File: tb/tb_uart_apb_tx.sv
// Directed self-checking bench for uart_apb_tx: register access, framing,
// parity, overflow, DMA request timing, back-to-back frames and reset.
module tb_uart_apb_tx;
  localparam logic [7:0] A_THR = 8'h00, A_LCR = 8'h04, A_DLL = 8'h08;
  localparam logic [7:0] A_DLM = 8'h0C, A_LSR = 8'h10, A_CNT = 8'h14;

  logic       PCLK = 1'b0;
  logic       PRESETn, PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA;
  logic       PREADY, PSLVERR, UART_SOUT, TXDRDYn, tx_irq;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_q[$];
  logic [7:0] rd;
  logic       er;
  int         lows;

  uart_apb_tx #(.FIFO_DEPTH(16), .DIV_W(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .UART_SOUT(UART_SOUT), .TXDRDYn(TXDRDYn), .tx_irq(tx_irq)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                     output logic [7:0] rdata, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    rdata = PRDATA;
    err   = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  function automatic void push_ones(input int n);
    repeat (n) exp_q.push_back(1'b1);
  endfunction

  // Reference frame: start, data LSB first, optional parity, stop bit(s).
  function automatic void push_frame(input logic [7:0] d, input logic [7:0] lcr, input int div);
    int   wl;
    int   ones;
    logic p;
    wl   = 5 + int'(lcr[1:0]);
    ones = 0;
    repeat (div) exp_q.push_back(1'b0);
    for (int b = 0; b < wl; b++) begin
      repeat (div) exp_q.push_back(d[b]);
      if (d[b]) ones++;
    end
    if (lcr[3]) begin
      if (lcr[5])      p = ~lcr[4];
      else if (lcr[4]) p = ones[0];
      else             p = ~ones[0];
      repeat (div) exp_q.push_back(p);
    end
    push_ones(div * (lcr[2] ? 2 : 1));
  endfunction

  task automatic run_capture(input string tag);
    int   nbad;
    int   first;
    logic fobs;
    logic fexp;
    nbad = 0; first = -1; fobs = 1'b0; fexp = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (UART_SOUT !== exp_q[i]) begin
        if (nbad == 0) begin
          first = i; fobs = UART_SOUT; fexp = exp_q[i];
        end
        nbad++;
      end
      @(posedge PCLK); #1;
    end
    n_checks++;
    assert (nbad == 0) else begin
      n_errors++;
      $error("FAIL %s: %0d bad cycles, first at cycle %0d observed %b expected %b",
             tag, nbad, first, fobs, fexp);
    end
    exp_q.delete();
  endtask

  task automatic parity_frame(input string tag, input logic [7:0] lcr, input logic [7:0] d);
    apb(1'b1, A_LCR, lcr, rd, er);
    apb(1'b1, A_THR, d, rd, er);
    push_ones(1);
    push_frame(d, lcr, 4);
    push_ones(3);
    run_capture(tag);
  endtask

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'h00; PWDATA = 8'h00;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_sout", 8'(UART_SOUT), 8'h01);
    chk("rst_pslverr", 8'(PSLVERR), 8'h00);
    chk("rst_prdata", PRDATA, 8'h00);
    chk("rst_txdrdyn", 8'(TXDRDYn), 8'h00);
    chk("rst_irq", 8'(tx_irq), 8'h00);
    chk("pready", 8'(PREADY), 8'h01);
    PRESETn = 1'b1;

    apb(1'b0, A_LCR, 8'h00, rd, er); chk("rst_lcr", rd, 8'h03); chk("lcr_rd_err", 8'(er), 8'h00);
    apb(1'b0, A_DLL, 8'h00, rd, er); chk("rst_dll", rd, 8'h00);
    apb(1'b0, A_DLM, 8'h00, rd, er); chk("rst_dlm", rd, 8'h00);
    apb(1'b0, A_LSR, 8'h00, rd, er); chk("rst_lsr", rd, 8'h05);
    apb(1'b0, A_CNT, 8'h00, rd, er); chk("rst_cnt", rd, 8'h00);
    apb(1'b0, A_THR, 8'h00, rd, er); chk("thr_read_err", 8'(er), 8'h01);
    apb(1'b0, 8'h18, 8'h00, rd, er); chk("unmapped_err", 8'(er), 8'h01);
    PADDR = A_LCR; #1;
    chk("prdata_unselected", PRDATA, 8'h00);

    // Idle transmitter with interrupt enabled raises tx_irq.
    apb(1'b1, A_LCR, 8'h83, rd, er); chk("irq_idle", 8'(tx_irq), 8'h01);
    apb(1'b1, A_LCR, 8'h03, rd, er); chk("irq_off", 8'(tx_irq), 8'h00);

    // Break forces the line low while set.
    apb(1'b1, A_LCR, 8'h43, rd, er);
    @(posedge PCLK); #1; chk("break_low", 8'(UART_SOUT), 8'h00);
    apb(1'b1, A_LCR, 8'h03, rd, er);
    @(posedge PCLK); #1; chk("break_release", 8'(UART_SOUT), 8'h01);

    // 8N1 at divisor 4, then parity / word-length / stop variants.
    apb(1'b1, A_DLL, 8'h04, rd, er);
    apb(1'b1, A_THR, 8'h55, rd, er);
    push_ones(1); push_frame(8'h55, 8'h03, 4); push_ones(4);
    run_capture("frame_55_8n1");
    parity_frame("frame_41_7e1", 8'h1A, 8'h41);
    parity_frame("frame_41_7o1", 8'h0A, 8'h41);
    parity_frame("frame_a3_8s1", 8'h2B, 8'hA3);
    parity_frame("frame_16_5s2", 8'h3C, 8'h16);
    apb(1'b1, A_LCR, 8'h03, rd, er);

    // Fill with divisor 0: nothing drains; check DMA request timing and overflow.
    apb(1'b1, A_DLL, 8'h00, rd, er);
    for (int i = 1; i <= 16; i++) begin
      apb(1'b1, A_THR, 8'h00, rd, er);
      if (i == 7) chk("txdrdyn_7", 8'(TXDRDYn), 8'h00);
      if (i == 8) begin
        chk("txdrdyn_8_same", 8'(TXDRDYn), 8'h00);
        @(posedge PCLK); #1;
        chk("txdrdyn_8_next", 8'(TXDRDYn), 8'h01);
      end
    end
    apb(1'b0, A_CNT, 8'h00, rd, er); chk("cnt_full", rd, 8'h10);
    apb(1'b1, A_THR, 8'h77, rd, er); chk("overflow_err", 8'(er), 8'h01);
    apb(1'b0, A_CNT, 8'h00, rd, er); chk("cnt_after_ovf", rd, 8'h10);
    apb(1'b0, A_LSR, 8'h00, rd, er); chk("lsr_ovf", rd, 8'h0A);
    apb(1'b1, A_LCR, 8'h83, rd, er); chk("irq_ovf", 8'(tx_irq), 8'h01);
    apb(1'b1, A_LSR, 8'h08, rd, er);
    apb(1'b0, A_LSR, 8'h00, rd, er); chk("lsr_cleared", rd, 8'h02);
    chk("irq_cleared", 8'(tx_irq), 8'h00);
    apb(1'b1, A_LCR, 8'h03, rd, er);

    // Start draining zeros, then reset in the middle of the data bits.
    apb(1'b1, A_DLL, 8'h04, rd, er);
    repeat (8) @(posedge PCLK);
    #1; chk("sout_data_low", 8'(UART_SOUT), 8'h00);
    #2; PRESETn = 1'b0;
    #1; chk("sout_async_rst", 8'(UART_SOUT), 8'h01);
    repeat (3) @(posedge PCLK);
    #1; PRESETn = 1'b1;
    apb(1'b0, A_CNT, 8'h00, rd, er); chk("cnt_after_rst", rd, 8'h00);
    apb(1'b0, A_LCR, 8'h00, rd, er); chk("lcr_after_rst", rd, 8'h03);
    apb(1'b0, A_LSR, 8'h00, rd, er); chk("lsr_after_rst", rd, 8'h05);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge PCLK); #1;
      if (UART_SOUT !== 1'b1) lows++;
    end
    chk("no_frame_after_rst", 8'(lows), 8'h00);

    // Two queued bytes go out back to back once the divisor is set.
    apb(1'b1, A_THR, 8'hA5, rd, er);
    apb(1'b1, A_THR, 8'h3C, rd, er);
    apb(1'b0, A_CNT, 8'h00, rd, er); chk("cnt_two", rd, 8'h02);
    apb(1'b1, A_DLL, 8'h04, rd, er);
    push_ones(1); push_frame(8'hA5, 8'h03, 4); push_frame(8'h3C, 8'h03, 4); push_ones(4);
    run_capture("back_to_back");

    // Divisor changed 4->8 during the first frame only affects the second.
    apb(1'b1, A_DLL, 8'h00, rd, er);
    apb(1'b1, A_THR, 8'h0F, rd, er);
    apb(1'b1, A_THR, 8'hF0, rd, er);
    apb(1'b1, A_DLL, 8'h04, rd, er);
    push_ones(1); push_frame(8'h0F, 8'h03, 4); push_frame(8'hF0, 8'h03, 8); push_ones(4);
    fork
      run_capture("div_change");
      begin
        repeat (10) @(posedge PCLK);
        apb(1'b1, A_DLL, 8'h08, rd, er);
      end
    join
    apb(1'b0, A_LSR, 8'h00, rd, er); chk("lsr_final", rd, 8'h05);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
